// File: rtl/cluster_reg_responder.sv
// Cluster local-bus responder: owns the shared register bank and answers
// one granted PE request at a time. RESP_PARITY_EN adds read-data parity.
module cluster_reg_responder #(
  parameter int NUM_PE     = 4,
  parameter int DATA_W     = 32,
  parameter int NREGS      = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_PE-1:0] grant,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic              req_read,
  input  logic [4:0]        sel_rd,
  input  logic [4:0]        sel_rs1,
  input  logic [4:0]        sel_rs2,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2,
  output logic [NUM_PE-1:0] mem_ack,
  output logic [NUM_PE-1:0] data_ready,
  output logic              busy,
  output logic              grant_err
`ifdef RESP_PARITY_EN
  ,
  output logic              rdata_par1,
  output logic              rdata_par2
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [NUM_PE-1:0] owner_q, owner_d;
  logic [NUM_PE-1:0] ack_q, ack_d;
  logic [NUM_PE-1:0] rdy_q, rdy_d;
  logic [4:0]        rs1_q, rs1_d;
  logic [4:0]        rs2_q, rs2_d;
  logic [DATA_W-1:0] dout1_q, dout1_d;
  logic [DATA_W-1:0] dout2_q, dout2_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] bank_q [NREGS];
  logic [DATA_W-1:0] bank_d [NREGS];
  logic              one_hot;

  assign one_hot = $onehot(grant);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    dout1_d = dout1_q;
    dout2_d = dout2_q;
    busy_d  = busy_q;
    err_d   = err_q;
    ack_d   = '0;
    rdy_d   = '0;
    bank_d  = bank_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (!one_hot) begin
            err_d = 1'b1;
          end else begin
            if (req_write && sel_rd != 5'd0) begin
              bank_d[sel_rd] = wdata;
            end
            if (!req_read) begin
              ack_d = grant;
            end else begin
              owner_d = grant;
              rs1_d   = sel_rs1;
              rs2_d   = sel_rs2;
              busy_d  = 1'b1;
              if (RD_LATENCY > 1) begin
                state_d = WAIT;
                cnt_d   = 3'(RD_LATENCY - 1);
              end else begin
                // bank_d already holds this request's write
                state_d = RESP;
                dout1_d = bank_d[sel_rs1];
                dout2_d = bank_d[sel_rs2];
                ack_d   = grant;
                rdy_d   = grant;
              end
            end
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = RESP;
          dout1_d = bank_q[rs1_q];
          dout2_d = bank_q[rs2_q];
          ack_d   = owner_q;
          rdy_d   = owner_q;
        end
      end
      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef RESP_PARITY_EN
  logic par1_q, par2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par1_q <= 1'b0;
      par2_q <= 1'b0;
    end else begin
      par1_q <= ^dout1_d;
      par2_q <= ^dout2_d;
    end
  end

  assign rdata_par1 = par1_q;
  assign rdata_par2 = par2_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      dout1_q <= '0;
      dout2_q <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      ack_q   <= '0;
      rdy_q   <= '0;
      bank_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      dout1_q <= dout1_d;
      dout2_q <= dout2_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      ack_q   <= ack_d;
      rdy_q   <= rdy_d;
      bank_q  <= bank_d;
    end
  end

  assign data_out1  = dout1_q;
  assign data_out2  = dout2_q;
  assign mem_ack    = ack_q;
  assign data_ready = rdy_q;
  assign busy       = busy_q;
  assign grant_err  = err_q;

endmodule

// File: tb/tb_cluster_reg_responder.sv
// Bench for cluster_reg_responder: latency-1 and latency-3 instances
// share stimulus; a timeline model predicts every output each cycle.
module tb_cluster_reg_responder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0]  grant = '0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic        req_read = 1'b0;
  logic [4:0]  sel_rd = '0;
  logic [4:0]  sel_rs1 = '0;
  logic [4:0]  sel_rs2 = '0;
  logic [31:0] wdata = '0;

  logic [1:0][31:0] d1, d2;
  logic [1:0][3:0]  ack, rdy;
  logic [1:0]       busy, err;
`ifdef RESP_PARITY_EN
  logic [1:0]       p1, p2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cluster_reg_responder #(.RD_LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .grant(grant),
    .req_valid(req_valid), .req_write(req_write),
    .req_read(req_read), .sel_rd(sel_rd),
    .sel_rs1(sel_rs1), .sel_rs2(sel_rs2), .wdata(wdata),
    .data_out1(d1[0]), .data_out2(d2[0]),
    .mem_ack(ack[0]), .data_ready(rdy[0]),
    .busy(busy[0]), .grant_err(err[0])
`ifdef RESP_PARITY_EN
    , .rdata_par1(p1[0]), .rdata_par2(p2[0])
`endif
  );

  cluster_reg_responder #(.RD_LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .grant(grant),
    .req_valid(req_valid), .req_write(req_write),
    .req_read(req_read), .sel_rd(sel_rd),
    .sel_rs1(sel_rs1), .sel_rs2(sel_rs2), .wdata(wdata),
    .data_out1(d1[1]), .data_out2(d2[1]),
    .mem_ack(ack[1]), .data_ready(rdy[1]),
    .busy(busy[1]), .grant_err(err[1])
`ifdef RESP_PARITY_EN
    , .rdata_par1(p1[1]), .rdata_par2(p2[1])
`endif
  );

  // Model: absolute edge numbers for busy windows and response edges
  int          lat [2] = '{1, 3};
  logic [31:0] m_bank [2][32];
  int          m_bend [2];
  int          m_redge [2];
  logic [3:0]  m_own [2];
  logic [4:0]  m_rs1 [2];
  logic [4:0]  m_rs2 [2];
  int          cyc = 0;

  logic [1:0][31:0] e_d1, e_d2;
  logic [1:0][3:0]  e_ack, e_rdy;
  logic [1:0]       e_busy, e_err;

  task automatic m_reset(int i);
    for (int j = 0; j < 32; j++) m_bank[i][j] = '0;
    m_bend[i]  = -100;
    m_redge[i] = -100;
    m_own[i]   = '0;
    m_rs1[i]   = '0;
    m_rs2[i]   = '0;
    e_d1[i]    = '0;
    e_d2[i]    = '0;
    e_ack[i]   = '0;
    e_rdy[i]   = '0;
    e_busy[i]  = 1'b0;
    e_err[i]   = 1'b0;
  endtask

  task automatic m_step(int i);
    e_ack[i] = '0;
    e_rdy[i] = '0;
    if (cyc >= m_bend[i] + 2 && req_valid) begin
      if ($countones(grant) != 1) begin
        e_err[i] = 1'b1;
      end else begin
        if (req_write && sel_rd != 0) m_bank[i][sel_rd] = wdata;
        if (req_read) begin
          m_bend[i]  = cyc + lat[i] - 1;
          m_redge[i] = cyc + lat[i] - 1;
          m_own[i]   = grant;
          m_rs1[i]   = sel_rs1;
          m_rs2[i]   = sel_rs2;
        end else begin
          e_ack[i] = grant;
        end
      end
    end
    if (cyc == m_redge[i]) begin
      e_d1[i]  = m_bank[i][m_rs1[i]];
      e_d2[i]  = m_bank[i][m_rs2[i]];
      e_ack[i] = m_own[i];
      e_rdy[i] = m_own[i];
    end
    e_busy[i] = (cyc <= m_bend[i]);
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_reset(0);
      m_reset(1);
    end else begin
      cyc = cyc + 1;
      m_step(0);
      m_step(1);
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h expected=%h",
               nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("m%0d data_out1", i), d1[i], e_d1[i]);
      chk($sformatf("m%0d data_out2", i), d2[i], e_d2[i]);
      chk($sformatf("m%0d mem_ack", i), 32'(ack[i]), 32'(e_ack[i]));
      chk($sformatf("m%0d data_ready", i), 32'(rdy[i]),
          32'(e_rdy[i]));
      chk($sformatf("m%0d busy", i), 32'(busy[i]), 32'(e_busy[i]));
      chk($sformatf("m%0d grant_err", i), 32'(err[i]),
          32'(e_err[i]));
`ifdef RESP_PARITY_EN
      chk($sformatf("m%0d par1", i), 32'(p1[i]), 32'(^e_d1[i]));
      chk($sformatf("m%0d par2", i), 32'(p2[i]), 32'(^e_d2[i]));
`endif
    end
  end

  task automatic req(input logic [3:0] g, input logic w,
                     input logic r, input logic [4:0] rd,
                     input logic [4:0] a, input logic [4:0] b,
                     input logic [31:0] wd);
    req_valid = 1'b1;
    grant     = g;
    req_write = w;
    req_read  = r;
    sel_rd    = rd;
    sel_rs1   = a;
    sel_rs2   = b;
    wdata     = wd;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(int n);
    req_valid = 1'b0;
    grant     = '0;
    req_write = 1'b0;
    req_read  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    idle(2);
    chk("rst d1", d1[0], 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst ack", 32'(ack), 32'h0);
    chk("rst err", 32'(err), 32'h0);
    reset = 1'b1;
    idle(1);

    // write r5 from PE1
    req(4'b0010, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF);
    chk("wr ack l1", 32'(ack[0]), 32'h2);
    chk("wr ack l3", 32'(ack[1]), 32'h2);
    chk("wr rdy", 32'(rdy[0]), 32'h0);
    chk("wr busy", 32'(busy), 32'h0);
    idle(1);

    // read r5/r0 from PE0
    req(4'b0001, 1'b0, 1'b1, 5'd0, 5'd5, 5'd0, 32'h0);
    chk("rd d1 l1", d1[0], 32'hDEADBEEF);
    chk("rd d2 l1", d2[0], 32'h0);
    chk("rd ack l1", 32'(ack[0]), 32'h1);
    chk("rd rdy l1", 32'(rdy[0]), 32'h1);
    chk("rd busy l1", 32'(busy[0]), 32'h1);
    chk("rd ack l3 early", 32'(ack[1]), 32'h0);
    idle(1);
    chk("rd busy l1 end", 32'(busy[0]), 32'h0);
    chk("rd rdy l3 early", 32'(rdy[1]), 32'h0);
    idle(1);
    chk("rd rdy l3", 32'(rdy[1]), 32'h1);
    chk("rd d1 l3", d1[1], 32'hDEADBEEF);
    idle(2);

    // write+read bypass
    req(4'b0100, 1'b1, 1'b1, 5'd7, 5'd7, 5'd5, 32'h12345678);
    chk("byp d1 l1", d1[0], 32'h12345678);
    chk("byp d2 l1", d2[0], 32'hDEADBEEF);
    idle(2);
    chk("byp d1 l3", d1[1], 32'h12345678);
    idle(2);

    // PE2 read, PE3 held while busy
    req(4'b0100, 1'b0, 1'b1, 5'd0, 5'd7, 5'd0, 32'h0);
    req(4'b1000, 1'b0, 1'b1, 5'd0, 5'd5, 5'd7, 32'h0);
    req(4'b1000, 1'b0, 1'b1, 5'd0, 5'd5, 5'd7, 32'h0);
    chk("bp rdy pe2", 32'(rdy[1]), 32'h4);
    chk("bp d1 pe2", d1[1], 32'h12345678);
    req(4'b1000, 1'b0, 1'b1, 5'd0, 5'd5, 5'd7, 32'h0);
    chk("bp held ack", 32'(ack[1]), 32'h0);
    chk("bp idle busy", 32'(busy[1]), 32'h0);
    req(4'b1000, 1'b0, 1'b1, 5'd0, 5'd5, 5'd7, 32'h0);
    chk("bp pe3 busy", 32'(busy[1]), 32'h1);
    idle(2);
    chk("bp rdy pe3", 32'(rdy[1]), 32'h8);
    chk("bp d1 pe3", d1[1], 32'hDEADBEEF);
    chk("bp d2 pe3", d2[1], 32'h12345678);
    idle(2);

    // bad grant, no-op request, r0 write
    req(4'b0110, 1'b1, 1'b0, 5'd9, 5'd0, 5'd0, 32'h55555555);
    chk("bad ack", 32'(ack), 32'h0);
    chk("bad err", 32'(err), 32'h3);
    idle(2);
    chk("bad err sticky", 32'(err), 32'h3);
    req(4'b1000, 1'b0, 1'b0, 5'd3, 5'd0, 5'd0, 32'h0);
    chk("noop ack", 32'(ack[0]), 32'h8);
    req(4'b0001, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF);
    chk("r0 wr ack", 32'(ack[0]), 32'h1);
    req(4'b0001, 1'b0, 1'b1, 5'd0, 5'd0, 5'd7, 32'h0);
    chk("r0 rd d1", d1[0], 32'h0);
    chk("r0 rd d2", d2[0], 32'h12345678);
    idle(2);
    chk("r0 rd d1 l3", d1[1], 32'h0);
    idle(2);

    // reset while the latency-3 instance waits
    req(4'b0010, 1'b0, 1'b1, 5'd0, 5'd7, 5'd9, 32'h0);
    chk("pre rst d1", d1[0], 32'h12345678);
    idle(1);
    chk("pre rst busy l3", 32'(busy[1]), 32'h1);
    #1 reset = 1'b0;
    #1;
    chk("mid rst d1", 32'(d1[0] | d1[1]), 32'h0);
    chk("mid rst busy", 32'(busy), 32'h0);
    chk("mid rst err", 32'(err), 32'h0);
    chk("mid rst ack", 32'(ack[1]), 32'h0);
    @(posedge clk);
    #2 reset = 1'b1;
    idle(1);
    req(4'b0010, 1'b0, 1'b1, 5'd0, 5'd7, 5'd5, 32'h0);
    chk("post rst d1", d1[0], 32'h0);
    chk("post rst d2", d2[0], 32'h0);
    idle(2);
    chk("post rst rdy l3", 32'(rdy[1]), 32'h2);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cluster_reg_responder.md
Name: cluster_reg_responder

Overview:
- Responder end of the cluster local bus: services the single arbitrated PE request and owns the shared cluster register bank.
- Accepts a granted read and/or write, commits writes, returns rs1/rs2 read data, and pulses per-PE mem_ack / data_ready back to the requesting bus interface.
- Sits between the bus arbiter/request mux and the four PE bus interfaces; one outstanding transaction at a time.

Parameters:
- NUM_PE, 4, number of PEs (width of grant/ack vectors)
- DATA_W, 32, register and data width
- NREGS, 32, register count; index width 5
- RD_LATENCY, 1, cycles from accept to read data valid (1..7)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- grant  input  NUM_PE  one-hot owner of the current request
- req_valid  input  1  request present this cycle
- req_write  input  1  write wdata to sel_rd
- req_read  input  1  read sel_rs1/sel_rs2
- sel_rd  input  5  destination register index
- sel_rs1  input  5  source register A index
- sel_rs2  input  5  source register B index
- wdata  input  DATA_W  write data (PE result)
- data_out1  output  DATA_W  rs1 read data (Amux side)
- data_out2  output  DATA_W  rs2 read data (Bmux side)
- mem_ack  output  NUM_PE  one-cycle accept/complete pulse to owner
- data_ready  output  NUM_PE  one-cycle read-data-valid pulse to owner
- busy  output  1  transaction in flight; new requests not accepted
- grant_err  output  1  sticky: request seen with non-one-hot grant

Behaviour:
- Reset (reset=0, async): all registers 0, data_out1/2=0, mem_ack=0, data_ready=0, busy=0, grant_err=0, FSM=IDLE.
- Register 0 reads as 0 always; writes to index 0 discarded (still acked).
- FSM states: IDLE, WAIT, RESP.
- IDLE: accept when req_valid=1 and grant is exactly one-hot. Latch owner, selects, wdata, read/write flags.
  - Write only: register written at the accept edge; mem_ack[owner]=1 on the next cycle; remain IDLE (busy stays 0).
  - Read (with or without write): busy=1; load countdown=RD_LATENCY-1; go to WAIT if RD_LATENCY>1, else RESP.
  - req_valid=1 with req_read=0 and req_write=0: acked like a write with no state change.
  - req_valid=1 with grant zero or multi-hot: ignored, no ack, grant_err set (cleared only by reset).
- WAIT: countdown decrements each cycle; at 0 go to RESP.
- RESP (one cycle): data_out1/2 updated with bank values for latched rs1/rs2; mem_ack[owner]=1 and data_ready[owner]=1 in that same cycle; busy=0 from the next cycle; return to IDLE.
- Read-after-write within the same request: if a write and read occur together and sel_rd equals sel_rs1/sel_rs2 (nonzero), the read returns the new wdata.
- data_out1/2 hold their last value between reads.
- Requests presented while busy=1 are neither accepted nor acked; the requester holds them. A request presented in the RESP cycle is not accepted.
- Ack latency: write = 1 cycle; read = RD_LATENCY cycles after the accept edge.
- reset asserted mid-transaction aborts it; no ack is issued; a pending write not yet committed is lost. A write committed at the accept edge is cleared by reset anyway.

Optional Feature:
- Macro RESP_PARITY_EN.
- Defined: adds outputs rdata_par1 and rdata_par2, each the even parity (XOR reduce) of data_out1 / data_out2. They update in the same cycle as the data and reset to 0.
- Undefined: those ports are absent; all other behaviour is identical.

Test Plan:
- Reset, then write: grant=0010, req_write=1, sel_rd=5, wdata=0xDEADBEEF -> mem_ack=0010 next cycle, data_ready=0000, busy stays 0.
- Read back, RD_LATENCY=1: grant=0001, req_read=1, rs1=5, rs2=0 -> RESP cycle shows data_out1=0xDEADBEEF, data_out2=0, mem_ack=data_ready=0001.
- Write+read bypass: sel_rd=7, rs1=7, wdata=0x12345678, both flags set -> data_out1=0x12345678 at RESP.
- Backpressure, RD_LATENCY=3: PE2 read accepted, PE3 request held while busy -> PE2 data_ready exactly 3 cycles after accept; PE3 accepted the cycle after RESP.
- Bad grant: req_valid=1, grant=0110 -> no ack, grant_err=1 sticky. Write to sel_rd=0 with 0xFFFFFFFF -> acked, later read of r0 returns 0.
- Reset mid-read (in WAIT) -> all outputs 0 immediately, no data_ready pulse, bank cleared.
